// File: rtl/burst_rx_fifo.sv
// burst_rx_fifo: receive-side show-ahead byte FIFO behind the serial shift-in
// stage. Buffers completed bytes for the host, and flags overrun, the fill
// threshold and a burst that has gone idle while data is still waiting.
module burst_rx_fifo #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int THRESH  = 8,
  parameter int TIMEOUT = 4096,
  parameter int TW      = 12
) (
  input  logic          E_CLK,
  input  logic          RESET,
  input  logic [7:0]    rx_byte,
  input  logic          rx_valid,
  input  logic          rd_strobe,
  input  logic          flush,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  output logic          overrun,
  output logic          stall,
  output logic          irq
);

  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   THRESH_L = (AW+1)'(THRESH);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          overrun_q, overrun_d;
  logic          stall_q, stall_d;
  logic          do_push, do_pop, drop;

  // Status decode from the registered level; rd_data shows the head entry.
  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == DEPTH_L);
    level   = level_q;
    overrun = overrun_q;
    stall   = stall_q;
    irq     = (level_q >= THRESH_L) | overrun_q | stall_q;
    rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];
  end

  // Push/pop qualification. A byte arriving while full is still accepted
  // when the host pops the same cycle, since a slot frees up at that edge.
  always_comb begin
    do_pop  = rd_strobe & ~empty;
    do_push = rx_valid & (~full | do_pop);
    drop    = rx_valid & full & ~do_pop;
  end

  // Next-state for pointers, level, idle timer and sticky flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    timer_d   = timer_q;
    overrun_d = overrun_q;
    stall_d   = stall_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (drop) overrun_d = 1'b1;

    // Stall looks at the timer before this edge's update, so a push on the
    // expiry edge does not mask it.
    if ((timer_q == TMAX) && !empty) stall_d = 1'b1;

    if (do_push || empty)  timer_d = '0;
    else if (timer_q != TMAX) timer_d = timer_q + 1'b1;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      timer_d   = '0;
      overrun_d = 1'b0;
      stall_d   = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge E_CLK) begin
    if (RESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      timer_q   <= '0;
      overrun_q <= 1'b0;
      stall_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      timer_q   <= timer_d;
      overrun_q <= overrun_d;
      stall_q   <= stall_d;
    end
  end

  // Byte storage; contents are never reset, only the pointers are.
  always_ff @(posedge E_CLK) begin
    if (do_push && !RESET && !flush) mem_q[wr_ptr_q] <= rx_byte;
  end

endmodule

// File: tb/tb_burst_rx_fifo.sv
// Testbench for burst_rx_fifo: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a queue-based reference model.
module tb_burst_rx_fifo;

  logic       E_CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rd_strobe = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, overrun, stall, irq;
  logic [4:0] level;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  byte unsigned mq[$];
  bit           m_ov, m_st;
  int           m_idle;

  burst_rx_fifo #(.DEPTH(16), .AW(4), .THRESH(8), .TIMEOUT(4096), .TW(12)) dut (
    .E_CLK(E_CLK), .RESET(RESET), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .rd_strobe(rd_strobe), .flush(flush), .rd_data(rd_data), .empty(empty),
    .full(full), .level(level), .overrun(overrun), .stall(stall), .irq(irq)
  );

  always #5 E_CLK = ~E_CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one edge's worth of behaviour to the model from the spec rules.
  task automatic model_edge(input bit v, input byte unsigned b, input bit r,
                            input bit f, input bit rs);
    int  sz;
    bit  pushed;
    if (rs || f) begin
      mq.delete();
      m_ov = 0; m_st = 0; m_idle = 0;
      return;
    end
    sz = mq.size();
    pushed = 0;
    if (m_idle == 4095 && sz != 0) m_st = 1;
    if (r && sz > 0) void'(mq.pop_front());
    if (v) begin
      if (sz < 16 || (r && sz > 0)) begin
        mq.push_back(b);
        pushed = 1;
      end else begin
        m_ov = 1;
      end
    end
    if (pushed || sz == 0) m_idle = 0;
    else if (m_idle < 4095) m_idle++;
  endtask

  task automatic check_all();
    int sz;
    sz = mq.size();
    chk("rd_data", rd_data, (sz > 0) ? mq[0] : 8'h00);
    chk("level",   level,   sz);
    chk("empty",   empty,   sz == 0);
    chk("full",    full,    sz == 16);
    chk("overrun", overrun, m_ov);
    chk("stall",   stall,   m_st);
    chk("irq",     irq,     (sz >= 8) || m_ov || m_st);
  endtask

  task automatic step(input bit v, input byte unsigned b, input bit r,
                      input bit f, input bit rs);
    RESET = rs; flush = f; rx_valid = v; rx_byte = b; rd_strobe = r;
    @(posedge E_CLK);
    model_edge(v, b, r, f, rs);
    #1;
    RESET = 1'b0; flush = 1'b0; rx_valid = 1'b0; rd_strobe = 1'b0;
    check_all();
  endtask

  task automatic push(input byte unsigned b); step(1, b, 0, 0, 0); endtask
  task automatic pop();                       step(0, 8'h00, 1, 0, 0); endtask
  task automatic do_flush();                  step(0, 8'h00, 0, 1, 0); endtask
  task automatic idle();                      step(0, 8'h00, 0, 0, 0); endtask

  initial begin
    byte unsigned t1[3];
    int pv, pr;
    t1[0] = 8'hA5; t1[1] = 8'h3C; t1[2] = 8'hFF;

    // Reset state
    step(1, 8'h11, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_irq", irq, 1'b0);

    // Scenario 1: ordered readback
    for (int i = 0; i < 3; i++) push(t1[i]);
    chk("s1_level3", level, 5'd3);
    for (int i = 0; i < 3; i++) begin
      chk("s1_head", rd_data, t1[i]);
      pop();
    end
    chk("s1_empty", empty, 1'b1);
    chk("s1_rd00", rd_data, 8'h00);
    pop();

    // Scenario 2: fill, then overflow byte dropped
    for (int i = 0; i < 16; i++) push(8'(i));
    chk("s2_full", full, 1'b1);
    push(8'hEE);
    chk("s2_overrun", overrun, 1'b1);
    chk("s2_irq", irq, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk("s2_head", rd_data, 8'(i));
      pop();
    end
    chk("s2_ov_sticky", overrun, 1'b1);
    do_flush();

    // Scenario 3: full with simultaneous push+pop
    for (int i = 0; i < 16; i++) push(8'(i));
    step(1, 8'h77, 1, 0, 0);
    chk("s3_level", level, 5'd16);
    chk("s3_no_ov", overrun, 1'b0);
    for (int i = 1; i < 16; i++) pop();
    chk("s3_last", rd_data, 8'h77);
    pop();
    do_flush();

    // Scenario 4: threshold irq
    for (int i = 0; i < 7; i++) push(8'(8'h40 + i));
    chk("s4_irq_lo", irq, 1'b0);
    push(8'h47);
    chk("s4_irq_hi", irq, 1'b1);
    pop();
    chk("s4_irq_drop", irq, 1'b0);
    do_flush();

    // Scenario 5: stall after idle timeout
    push(8'h5A);
    for (int i = 0; i < 4095; i++) idle();
    chk("s5_stall_pre", stall, 1'b0);
    idle();
    chk("s5_stall_set", stall, 1'b1);
    pop();
    chk("s5_stall_sticky", stall, 1'b1);
    do_flush();
    chk("s5_flush_stall", stall, 1'b0);
    chk("s5_flush_level", level, 5'd0);

    // Scenario 6: flush / reset beat push+pop in the same cycle
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i));
    step(1, 8'h99, 1, 1, 0);
    chk("s6_flush_level", level, 5'd0);
    chk("s6_flush_empty", empty, 1'b1);
    for (int i = 0; i < 3; i++) push(8'(8'h70 + i));
    step(1, 8'h99, 1, 0, 1);
    chk("s6_rst_level", level, 5'd0);
    chk("s6_rst_empty", empty, 1'b1);

    // Randomized traffic with phases of varying push/pop bias
    for (int ph = 0; ph < 30; ph++) begin
      pv = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 100; c++) begin
        step(($urandom_range(0, 99) < pv), 8'($urandom),
             ($urandom_range(0, 99) < pr),
             ($urandom_range(0, 199) == 0),
             ($urandom_range(0, 399) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
